usb_bulk_in_arbiter: RTL
========================

// Module: usb_bulk_in_arbiter
// PURPOSE
//  Shares the single USB BULK IN endpoint datapath (blki_* AXI-S into usb_ulpi_top) between
//  NUM_CH byte-stream sources. Sequences one IN packet per blk_start_i for endpoint ENDPOINT.
//  Grants channels round-robin and caps packets at MAX_PKT bytes. Sits between the
//  application streams and the USB core, in the usb_clock domain.
// PARAMETERS
//  NUM_CH    4    number of source channels, 2..8
//  ENDPOINT  2    BULK IN endpoint number served; other blk_endpt_i values are ignored
//  MAX_PKT   512  max bytes per IN packet (power of 2, 8..512)
// PORTS
//  clock          in   1        usb_clock, all logic rising-edge
//  reset          in   1        asynchronous, active-high
//  blk_start_i    in   1        bulk transaction start pulse from USB core
//  blk_cycle_i    in   1        bulk transaction in progress
//  blk_fetch_i    in   1        transaction is IN (device->host)
//  blk_endpt_i    in   4        endpoint of current transaction
//  src_tvalid_i   in   NUM_CH   per-channel data valid
//  src_tready_o   out  NUM_CH   per-channel ready (one-hot or zero)
//  src_tlast_i    in   NUM_CH   per-channel end of source packet
//  src_tdata_i    in   8*NUM_CH channel i at [8i+7:8i]
//  blki_tvalid_o  out  1        to USB core BULK IN
//  blki_tready_i  in   1
//  blki_tlast_o   out  1
//  blki_tkeep_o   out  1        0 only for zero-length packet
//  blki_tdata_o   out  8
//  grant_o        out  NUM_CH   registered one-hot grant, 0 when idle
//  busy_o         out  1        high in any state but IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = 0; byte count = 0; sticky flag = 0.
//  States: IDLE -> ARB -> XFER|ZLP -> WAIT -> IDLE.
//  IDLE: blk_start_i & blk_fetch_i & blk_endpt_i==ENDPOINT -> ARB. Anything else is ignored.
//   blk_start_i is also ignored in every non-IDLE state.
//  ARB (1 cycle): if sticky set, re-grant the same channel. Otherwise pick the first i with
//   src_tvalid_i[i] set, searching from rr pointer upward with wrap. Grant found -> XFER.
//   None found -> ZLP.
//  XFER: data mux is combinational from the registered grant g.
//   blki_tvalid_o = src_tvalid_i[g]; blki_tdata_o = src_tdata_i[g]; blki_tkeep_o = 1.
//   src_tready_o[g] = blki_tready_i; all other src_tready_o bits stay 0.
//   blki_tlast_o = src_tlast_i[g] | (count == MAX_PKT-1).
//   count increments on each blki_tvalid_o & blki_tready_i; count width is log2(MAX_PKT).
//  Packet end (tvalid & tready & tlast) -> WAIT, count cleared.
//   If src_tlast_i[g] was set: sticky=0, rr = g+1 mod NUM_CH.
//   If ended by the MAX_PKT cap only: sticky=1, rr unchanged; the next IN continues channel g.
//  Latency: first byte may be presented 2 cycles after the blk_start_i cycle.
//  WAIT: hold until blk_cycle_i==0, then -> IDLE, grant_o cleared.
//  Abort: blk_cycle_i falls during XFER/ZLP -> IDLE immediately; src_tready_o forced 0.
//   rr and sticky are unchanged; count cleared. Bytes already accepted are lost (documented).
//  Simultaneous: byte transfer and blk_cycle_i fall in the same cycle -> byte counts, then
//   abort applies. Reset mid-operation returns to reset values asynchronously.
// CONFIGURATION
//  USB_BULK_ARB_ZLP_EN defined: ZLP state drives blki_tvalid_o=1, blki_tlast_o=1,
//   blki_tkeep_o=0 until blki_tready_i, then -> WAIT.
//  Undefined: ZLP state drives nothing (tvalid=0) and waits for blk_cycle_i==0 -> IDLE.
//   The core's timeout/NAK handles the empty endpoint.
// TESTING
//  1 Ch1 holds a 5-byte pkt, others idle; IN on EP2 -> 5 bytes from ch1, tlast on 5th,
//    grant_o=0010, rr becomes 2.
//  2 Ch0 and ch2 both valid, rr=0; three INs -> ch0, then ch2, then ch0 (wrap); no byte
//    interleave between channels.
//  3 Ch3 sends 700 bytes, MAX_PKT=512 -> pkt1 is 512 bytes with forced tlast; the next IN
//    re-grants ch3 even with ch0 valid; pkt2 is 188 bytes; then rr=0.
//  4 No channel valid: with _ZLP_EN, one beat tkeep=0/tlast=1; without it, tvalid stays 0
//    and the block is back in IDLE after blk_cycle_i falls.
//  5 blk_cycle_i dropped after 3 bytes of 10 -> src_tready_o=0 next cycle, state IDLE,
//    next IN re-selects the same channel.
//  6 blk_endpt_i=1, or blk_fetch_i=0, with blk_start_i -> no grant, busy_o stays 0;
//    assert reset mid-XFER -> all outputs 0.

Source files
------------

// File: rtl/usb_bulk_in_arbiter.sv
// usb_bulk_in_arbiter: round-robin arbiter that shares one USB BULK IN endpoint among NUM_CH byte streams
//
// Each IN transaction on ENDPOINT becomes one packet from one granted channel. A packet is
// capped at MAX_PKT bytes. When the cap ends a packet, the next IN continues the same channel.
// Optional feature macro: USB_BULK_ARB_ZLP_EN. When it is defined, an IN with no data pending
// returns a zero-length packet. Otherwise the endpoint stays silent and the core NAKs.
//
// Ports (all in the usb_clock domain, rising edge):
//   clock, reset            clock, asynchronous active-high reset
//   blk_start_i             transaction start pulse from the USB core
//   blk_cycle_i             transaction in progress; a fall during data aborts the packet
//   blk_fetch_i             transaction is IN (device to host)
//   blk_endpt_i[3:0]        endpoint of the current transaction
//   src_tvalid_i/_tlast_i   per-channel AXI-S valid and end-of-packet
//   src_tdata_i             per-channel bytes, channel i at [8i+7:8i]
//   src_tready_o            per-channel ready, only the granted bit can be set
//   blki_*                  AXI-S byte stream into the core's BULK IN port
//   grant_o                 registered one-hot grant, zero when idle
//   busy_o                  high whenever the sequencer is not idle
module usb_bulk_in_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int ENDPOINT = 2,
    parameter int MAX_PKT  = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  blk_start_i,
    input  logic                  blk_cycle_i,
    input  logic                  blk_fetch_i,
    input  logic [3:0]            blk_endpt_i,
    input  logic [NUM_CH-1:0]     src_tvalid_i,
    output logic [NUM_CH-1:0]     src_tready_o,
    input  logic [NUM_CH-1:0]     src_tlast_i,
    input  logic [8*NUM_CH-1:0]   src_tdata_i,
    output logic                  blki_tvalid_o,
    input  logic                  blki_tready_i,
    output logic                  blki_tlast_o,
    output logic                  blki_tkeep_o,
    output logic [7:0]            blki_tdata_o,
    output logic [NUM_CH-1:0]     grant_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(MAX_PKT);
    localparam int IW = $clog2(NUM_CH);

    typedef enum logic [2:0] {IDLE, ARB, XFER, ZLP, WAIT} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     rr, rr_nx, gidx, gidx_nx, pick;
    logic [CW-1:0]     count, count_nx;
    logic [NUM_CH-1:0] grant_nx;
    logic              sticky, sticky_nx, found, beat, cap;
    logic [7:0]        src_data [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_data
        assign src_data[i] = src_tdata_i[8*i +: 8];
    end

    assign busy_o = state != IDLE;
    assign cap    = count == CW'(MAX_PKT - 1);

    // Search downward so the channel closest to rr (in wrap order) is the last one written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (src_tvalid_i[IW'((int'(rr) + k) % NUM_CH)]) begin
                found = 1'b1;
                pick  = IW'((int'(rr) + k) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr      <= '0;
            gidx    <= '0;
            sticky  <= 1'b0;
            count   <= '0;
            grant_o <= '0;
        end else begin
            state   <= state_nx;
            rr      <= rr_nx;
            gidx    <= gidx_nx;
            sticky  <= sticky_nx;
            count   <= count_nx;
            grant_o <= grant_nx;
        end
    end

    always_comb begin
        blki_tvalid_o = 1'b0;
        blki_tlast_o  = 1'b0;
        blki_tkeep_o  = 1'b0;
        blki_tdata_o  = '0;
        src_tready_o  = '0;
        state_nx      = state;
        rr_nx         = rr;
        gidx_nx       = gidx;
        sticky_nx     = sticky;
        count_nx      = count;
        grant_nx      = grant_o;
        if (state == XFER) begin
            blki_tvalid_o      = src_tvalid_i[gidx];
            blki_tdata_o       = src_data[gidx];
            blki_tkeep_o       = 1'b1;
            blki_tlast_o       = src_tlast_i[gidx] | cap;
            src_tready_o[gidx] = blki_tready_i;
        end
`ifdef USB_BULK_ARB_ZLP_EN
        if (state == ZLP) begin
            blki_tvalid_o = 1'b1;
            blki_tlast_o  = 1'b1;
        end
`endif
        beat = blki_tvalid_o & blki_tready_i;
        case (state)
            IDLE: begin
                if (blk_start_i && blk_fetch_i && blk_endpt_i == 4'(ENDPOINT))
                    state_nx = ARB;
            end
            ARB: begin
                if (sticky || found) begin
                    gidx_nx           = sticky ? gidx : pick;
                    grant_nx          = '0;
                    grant_nx[gidx_nx] = 1'b1;
                    state_nx          = XFER;
                end else begin
                    state_nx = ZLP;
                end
            end
            XFER: begin
                if (beat) begin
                    count_nx = count + CW'(1);
                    if (blki_tlast_o) begin
                        count_nx = '0;
                        state_nx = WAIT;
                        // A source tlast closes the channel's stream; a cap-only end keeps it owed.
                        sticky_nx = ~src_tlast_i[gidx];
                        if (src_tlast_i[gidx])
                            rr_nx = (gidx == IW'(NUM_CH - 1)) ? '0 : gidx + IW'(1);
                    end
                end
                // The final byte of an aborted cycle still counts, then the packet is dropped.
                if (!blk_cycle_i) begin
                    state_nx = IDLE;
                    count_nx = '0;
                    grant_nx = '0;
                end
            end
            ZLP: begin
`ifdef USB_BULK_ARB_ZLP_EN
                if (blki_tready_i)
                    state_nx = WAIT;
`endif
                if (!blk_cycle_i)
                    state_nx = IDLE;
            end
            WAIT: begin
                if (!blk_cycle_i) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
